// File: rtl/demux_1x2_8bit_buf_pkg.sv
// Shared defaults and destination-select encodings for the 1:2 buffered byte demultiplexer.
package demux_1x2_8bit_buf_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2;
  localparam int CNT_W_DEF  = 16;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  typedef enum logic {
    DST_OUT0 = SEL_OUT0,
    DST_OUT1 = SEL_OUT1
  } dst_e;

  function automatic logic sel_hits(input logic sel, input dst_e dst);
    return sel == logic'(dst);
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// Small synchronous FIFO with registered full/empty; one instance per demux output.
module demux_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == OCC_FULL);
  assign data_o  = mem_q[rd_ptr_q];

  // Guarded locally so a misbehaving parent can never overrun or underrun the storage.
  assign wr_en = push_i && !full_o;
  assign rd_en = pop_i && !empty_o;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    count_d = count_q + (PTR_W + 1)'(wr_en) - (PTR_W + 1)'(rd_en);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is cleared on reset so an empty output presents zero rather than stale data;
  // this is deliberate and keeps the array in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/demux_1x2_8bit_buf.sv
// 1:2 byte demultiplexer: one valid/ready source steered per beat into two independently
// stalling FIFO-buffered sinks, with per-output delivered-beat counters.
module demux_1x2_8bit_buf
  import demux_1x2_8bit_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic              full0,
  output logic              full1,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  logic             push0, push1;
  logic             pop0, pop1;
  logic             empty0, empty1;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Ready looks only at the registered full flag of the selected side: no sink-to-source comb path.
  assign in_ready = sel_hits(in_sel, DST_OUT1) ? !full1 : !full0;

  // in_valid gates first so an undefined in_sel on an idle cycle cannot reach any state.
  assign push0 = in_valid && in_ready && sel_hits(in_sel, DST_OUT0);
  assign push1 = in_valid && in_ready && sel_hits(in_sel, DST_OUT1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push0),
    .pop_i   (pop0),
    .data_i  (in_data),
    .data_o  (out0_data),
    .empty_o (empty0),
    .full_o  (full0)
  );

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push1),
    .pop_i   (pop1),
    .data_i  (in_data),
    .data_o  (out1_data),
    .empty_o (empty1),
    .full_o  (full1)
  );

  // Counters wrap silently at 2^CNT_W.
  always_comb begin
    cnt0_d = cnt0_q + CNT_W'(pop0);
    cnt1_d = cnt1_q + CNT_W'(pop1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux_1x2_8bit_buf.sv
// Scoreboard bench: the driver queues each accepted beat per destination; a monitor compares
// the sink outputs, flags and counters against those queues every cycle.
module tb_demux_1x2_8bit_buf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rst_drive = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_sel = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out0_data, out1_data;
  logic              out0_valid, out1_valid;
  logic              out0_ready = 1'b0;
  logic              out1_ready = 1'b0;
  logic              full0, full1;
  logic [CNT_W-1:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  demux_1x2_8bit_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .full0      (full0),
    .full1      (full1),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  // Reference model: each destination is an ordered list of beats accepted and not yet consumed.
  logic [DATA_W-1:0] exp_q [2][$];
  logic [CNT_W-1:0]  exp_cnt [2];
  bit                exp_zero [2];
  bit                pend_pop [2];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare at the falling edge, retire consumed beats at the following rising edge.
  initial begin
    for (int n = 0; n < 2; n++) begin
      exp_cnt[n]  = '0;
      exp_zero[n] = 1'b1;
      pend_pop[n] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int n = 0; n < 2; n++) begin
        logic              v, f, r;
        logic [DATA_W-1:0] d;
        logic [CNT_W-1:0]  c;
        v = (n == 0) ? out0_valid : out1_valid;
        f = (n == 0) ? full0 : full1;
        r = (n == 0) ? out0_ready : out1_ready;
        d = (n == 0) ? out0_data : out1_data;
        c = (n == 0) ? cnt0 : cnt1;
        check($sformatf("out%0d_valid", n), 32'(v), 32'(exp_q[n].size() != 0));
        check($sformatf("full%0d", n), 32'(f), 32'(exp_q[n].size() == DEPTH));
        check($sformatf("cnt%0d", n), 32'(c), 32'(exp_cnt[n]));
        if (exp_q[n].size() != 0)
          check($sformatf("out%0d_data", n), 32'(d), 32'(exp_q[n][0]));
        else if (exp_zero[n])
          check($sformatf("out%0d_data_rst", n), 32'(d), 32'h0);
        pend_pop[n] = rst_n && (exp_q[n].size() != 0) && r;
      end
      @(posedge clk);
      for (int n = 0; n < 2; n++) begin
        if (!rst_n) begin
          exp_q[n].delete();
          exp_cnt[n]  = '0;
          exp_zero[n] = 1'b1;
        end else if (pend_pop[n]) begin
          void'(exp_q[n].pop_front());
          exp_cnt[n] = exp_cnt[n] + 1'b1;
        end
      end
    end
  end

  // Driver: one clock per call; inputs change just after the rising edge.
  task automatic cycle(input logic v, input logic s, input logic [DATA_W-1:0] d,
                       input logic r0, input logic r1);
    logic exp_rdy;
    @(posedge clk);
    #1;
    rst_n      = rst_drive;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    @(negedge clk);
    #1;
    exp_rdy = (exp_q[s].size() != DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (rst_n && v && exp_rdy) begin
      exp_q[s].push_back(d);
      exp_zero[s] = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_drive = 1'b0;
    repeat (cycles) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    rst_drive = 1'b1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset then idle.
    do_reset(2);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Routing one beat to each sink.
    cycle(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("cnt0_after_route", 32'(cnt0), 32'd1);
    check("cnt1_after_route", 32'(cnt1), 32'd1);

    // Fill FIFO 0, stall, keep FIFO 1 flowing, then drain with the pop-cycle stall.
    cycle(1'b1, 1'b0, 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h02, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h03, 1'b0, 1'b1);
    check("full0_after_fill", 32'(full0), 32'd1);
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 8'h03, 1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("cnt0_after_drain", 32'(cnt0), 32'd4);

    // Simultaneous push and pop on FIFO 1 holding one entry.
    cycle(1'b1, 1'b1, 8'h11, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 8'hBE, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("fifo1_head_be", 32'(out1_data), 32'hBE);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Reset with FIFO 0 full.
    cycle(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
    do_reset(1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("cnt0_after_midreset", 32'(cnt0), 32'd0);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) do_reset(1);
      cycle(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 1)), 8'($urandom),
            logic'($urandom_range(0, 9) < 6), logic'($urandom_range(0, 9) < 6));
    end
    repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Counter wrap on output 1: 65536 deliveries in total.
    do_reset(1);
    cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
    repeat (65535) cycle(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("cnt1_at_ffff", 32'(cnt1), 32'hFFFF);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("cnt1_wrapped", 32'(cnt1), 32'h0);
    check("cnt0_untouched", 32'(cnt0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
